// File: rtl/fpu_types_pkg.sv
// Shared FPU types: exception flags, rounding-mode encodings and FP CSR write selectors.
package fpu_types;

  localparam int FFLAGS_BITS = 5;

  // Bit order matches the RISC-V fflags field: NV is the MSB, NX the LSB.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [2:0] {
    FRM_RNE = 3'd0,
    FRM_RTZ = 3'd1,
    FRM_RDN = 3'd2,
    FRM_RUP = 3'd3,
    FRM_RMM = 3'd4,
    FRM_DYN = 3'd7
  } frm_e;

  localparam logic [1:0] FCSR_SEL_NONE   = 2'd0;
  localparam logic [1:0] FCSR_SEL_FFLAGS = 2'd1;
  localparam logic [1:0] FCSR_SEL_FRM    = 2'd2;
  localparam logic [1:0] FCSR_SEL_ALL    = 2'd3;

  function automatic logic fcsr_sel_writes_fflags(input logic [1:0] sel);
    return (sel == FCSR_SEL_FFLAGS) || (sel == FCSR_SEL_ALL);
  endfunction

  function automatic logic fcsr_sel_writes_frm(input logic [1:0] sel);
    return (sel == FCSR_SEL_FRM) || (sel == FCSR_SEL_ALL);
  endfunction

endpackage

// File: rtl/fpu_fflags_reduce.sv
// Masked OR of per-lane exception flags into a single fflags_t.
module fpu_fflags_reduce
  import fpu_types::*;
#(
  parameter int NUM_LANES = 4
) (
  input  fflags_t [NUM_LANES-1:0] lane_flags,
  input  logic    [NUM_LANES-1:0] tmask,
  output fflags_t                 flags
);

  always_comb begin
    flags = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tmask[i]) flags = fflags_t'(flags | lane_flags[i]);
    end
  end

endmodule

// File: rtl/fpu_fflags_csr.sv
// Per-warp sticky fflags accumulation and frm/fflags/fcsr CSR storage.
// Build option: FPU_FFLAGS_BYPASS_EN forwards the pending stage-1 flags into CSR reads.
module fpu_fflags_csr
  import fpu_types::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4,
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             commit_valid,
  output logic                             commit_ready,
  input  logic [WID_W-1:0]                 commit_wid,
  input  logic [NUM_LANES-1:0]             commit_tmask,
  input  logic                             commit_has_fflags,
  input  logic [NUM_LANES*FFLAGS_BITS-1:0] commit_fflags,
  input  logic [WID_W-1:0]                 csr_read_wid,
  output logic [4:0]                       csr_read_fflags,
  output logic [2:0]                       csr_read_frm,
  output logic                             csr_read_busy,
  input  logic                             csr_write_valid,
  input  logic [WID_W-1:0]                 csr_write_wid,
  input  logic [1:0]                       csr_write_sel,
  input  logic [7:0]                       csr_write_data
);

  // Per-warp state in fcsr layout {frm[2:0], fflags[4:0]}.
  logic [7:0]  fcsr_q [NUM_WARPS];

  fflags_t     reduced_p0;
  logic        commit_fire_p0;
  logic        vld_p1;
  logic [WID_W-1:0] wid_p1;
  fflags_t     flags_p1;

  logic        wr_fflags;
  logic        wr_frm;
  logic [7:0]  read_fcsr;
  logic        busy_p0;
  logic        busy_p1;

  assign commit_ready   = ~reset;
  assign commit_fire_p0 = commit_valid && commit_ready && commit_has_fflags && (|commit_tmask);

  fpu_fflags_reduce #(
    .NUM_LANES (NUM_LANES)
  ) u_reduce (
    .lane_flags (commit_fflags),
    .tmask      (commit_tmask),
    .flags      (reduced_p0)
  );

  // Stage 0 -> 1: capture the lane-reduced flags and target warp.
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= commit_fire_p0;
  end

  always_ff @(posedge clk) begin
    if (commit_fire_p0) begin
      wid_p1   <= commit_wid;
      flags_p1 <= reduced_p0;
    end
  end

  assign wr_fflags = csr_write_valid && fcsr_sel_writes_fflags(csr_write_sel);
  assign wr_frm    = csr_write_valid && fcsr_sel_writes_frm(csr_write_sel);

  // Stage 1 -> state: sticky merge; a same-edge CSR write is younger and overrides the fields it writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) fcsr_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (vld_p1 && wid_p1 == WID_W'(w))
          fcsr_q[w][4:0] <= fcsr_q[w][4:0] | flags_p1;
        if (wr_fflags && csr_write_wid == WID_W'(w))
          fcsr_q[w][4:0] <= csr_write_data[4:0];
        if (wr_frm && csr_write_wid == WID_W'(w))
          fcsr_q[w][7:5] <= csr_write_data[7:5];
      end
    end
  end

  assign read_fcsr    = fcsr_q[csr_read_wid];
  assign csr_read_frm = read_fcsr[7:5];
  assign busy_p0      = commit_fire_p0 && (commit_wid == csr_read_wid);
  assign busy_p1      = vld_p1 && (wid_p1 == csr_read_wid);

`ifdef FPU_FFLAGS_BYPASS_EN
  assign csr_read_fflags = busy_p1 ? (read_fcsr[4:0] | flags_p1) : read_fcsr[4:0];
  assign csr_read_busy   = busy_p0;
`else
  assign csr_read_fflags = read_fcsr[4:0];
  assign csr_read_busy   = busy_p0 || busy_p1;
`endif

endmodule

// File: tb/tb_fpu_fflags_csr.sv
// Directed bench for fpu_fflags_csr: table of single commits plus hand-written corner sequences.
module tb_fpu_fflags_csr;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic        commit_ready;
  logic [1:0]  commit_wid;
  logic [3:0]  commit_tmask;
  logic        commit_has_fflags;
  logic [19:0] commit_fflags;
  logic [1:0]  csr_read_wid;
  logic [4:0]  csr_read_fflags;
  logic [2:0]  csr_read_frm;
  logic        csr_read_busy;
  logic        csr_write_valid;
  logic [1:0]  csr_write_wid;
  logic [1:0]  csr_write_sel;
  logic [7:0]  csr_write_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_fflags_csr #(.NUM_WARPS(4), .NUM_LANES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .commit_valid      (commit_valid),
    .commit_ready      (commit_ready),
    .commit_wid        (commit_wid),
    .commit_tmask      (commit_tmask),
    .commit_has_fflags (commit_has_fflags),
    .commit_fflags     (commit_fflags),
    .csr_read_wid      (csr_read_wid),
    .csr_read_fflags   (csr_read_fflags),
    .csr_read_frm      (csr_read_frm),
    .csr_read_busy     (csr_read_busy),
    .csr_write_valid   (csr_write_valid),
    .csr_write_wid     (csr_write_wid),
    .csr_write_sel     (csr_write_sel),
    .csr_write_data    (csr_write_data)
  );

  typedef struct packed {
    logic [1:0]       wid;
    logic [3:0]       tmask;
    logic             has;
    logic [19:0]      flags;
    logic [3:0][4:0]  exp;   // expected fflags of warps {3,2,1,0} after the merge
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_fflags(input logic [1:0] w, input string name, input int exp);
    csr_read_wid = w;
    #1;
    chk(name, csr_read_fflags, exp);
  endtask

  task automatic read_frm(input logic [1:0] w, input string name, input int exp);
    csr_read_wid = w;
    #1;
    chk(name, csr_read_frm, exp);
  endtask

  task automatic drive_commit(input logic [1:0] w, input logic [3:0] m, input logic h, input logic [19:0] f);
    commit_valid      = 1'b1;
    commit_wid        = w;
    commit_tmask      = m;
    commit_has_fflags = h;
    commit_fflags     = f;
  endtask

  task automatic idle_commit();
    commit_valid      = 1'b0;
    commit_has_fflags = 1'b0;
    commit_tmask      = '0;
    commit_fflags     = '0;
  endtask

  task automatic drive_write(input logic [1:0] w, input logic [1:0] sel, input logic [7:0] d);
    csr_write_valid = 1'b1;
    csr_write_wid   = w;
    csr_write_sel   = sel;
    csr_write_data  = d;
  endtask

  task automatic idle_write();
    csr_write_valid = 1'b0;
    csr_write_sel   = 2'd0;
    csr_write_data  = '0;
  endtask

  initial begin
    logic [4:0] seq_flag [8];

    // lane i occupies commit_fflags[5i+4:5i]; NV=10 DZ=08 OF=04 UF=02 NX=01
    vecs[0] = '{2'd2, 4'b0101, 1'b1, 20'h02001, {5'h00, 5'h09, 5'h00, 5'h00}};
    vecs[1] = '{2'd1, 4'b0010, 1'b1, 20'h00090, {5'h00, 5'h09, 5'h04, 5'h00}};
    vecs[2] = '{2'd0, 4'b1111, 1'b0, 20'h84210, {5'h00, 5'h09, 5'h04, 5'h00}};
    vecs[3] = '{2'd3, 4'b0000, 1'b1, 20'h08421, {5'h00, 5'h09, 5'h04, 5'h00}};
    vecs[4] = '{2'd3, 4'b1111, 1'b1, 20'h81041, {5'h17, 5'h09, 5'h04, 5'h00}};
    vecs[5] = '{2'd0, 4'b0110, 1'b1, 20'h00510, {5'h17, 5'h09, 5'h04, 5'h09}};
    vecs[6] = '{2'd2, 4'b1111, 1'b1, 20'h08421, {5'h17, 5'h09, 5'h04, 5'h09}};

    seq_flag = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02, 5'h04};

    reset = 1'b1;
    csr_read_wid  = 2'd0;
    csr_write_wid = 2'd0;
    commit_wid    = 2'd0;
    idle_commit();
    idle_write();
    step();
    step();
    chk("ready_in_reset", commit_ready, 0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", commit_ready, 1);
    read_fflags(2'd0, "reset_fflags_w0", 0);
    read_frm(2'd0, "reset_frm_w0", 0);
    chk("reset_busy", csr_read_busy, 0);

    // Table-driven single commits, each checked on every warp after two edges
    for (int v = 0; v < 7; v++) begin
      drive_commit(vecs[v].wid, vecs[v].tmask, vecs[v].has, vecs[v].flags);
      step();
      idle_commit();
      step();
      for (int w = 0; w < 4; w++)
        read_fflags(2'(w), $sformatf("vec%0d_w%0d", v, w), vecs[v].exp[w]);
    end

    // Read of warp 1 the cycle after a UF commit
    csr_read_wid = 2'd1;
    drive_commit(2'd1, 4'b1000, 1'b1, 20'h10000);
    #1;
    chk("busy_same_cycle_commit", csr_read_busy, 1);
    step();
    idle_commit();
    #1;
`ifdef FPU_FFLAGS_BYPASS_EN
    chk("busy_stage1", csr_read_busy, 0);
    chk("fflags_stage1", csr_read_fflags, 5'h06);
`else
    chk("busy_stage1", csr_read_busy, 1);
    chk("fflags_stage1", csr_read_fflags, 5'h04);
`endif
    step();
    chk("busy_settled", csr_read_busy, 0);
    read_fflags(2'd1, "w1_after_uf", 5'h06);

    // Merge vs same-edge fcsr write on warp 3
    drive_write(2'd3, 2'd3, 8'h00);
    step();
    idle_write();
    read_fflags(2'd3, "w3_cleared", 0);
    drive_commit(2'd3, 4'b0001, 1'b1, 20'h00001);
    step();
    idle_commit();
    drive_write(2'd3, 2'd3, 8'hE0);
    step();
    idle_write();
    read_fflags(2'd3, "fcsr_wins_fflags", 0);
    read_frm(2'd3, "fcsr_wins_frm", 7);
    drive_commit(2'd3, 4'b0001, 1'b1, 20'h00001);
    step();
    idle_commit();
    drive_write(2'd3, 2'd2, 8'h20);
    step();
    idle_write();
    read_fflags(2'd3, "frm_write_keeps_nx", 5'h01);
    read_frm(2'd3, "frm_write_value", 1);

    // Reserved frm value stored verbatim; fflags-only write leaves frm
    drive_write(2'd1, 2'd2, 8'hC0);
    step();
    drive_write(2'd1, 2'd1, 8'h1B);
    step();
    idle_write();
    read_frm(2'd1, "frm_reserved_6", 6);
    read_fflags(2'd1, "fflags_write_w1", 5'h1B);

    // Reset between capture and merge discards the pending merge
    drive_commit(2'd0, 4'b0001, 1'b1, 20'h00008);
    step();
    idle_commit();
    reset = 1'b1;
    #1;
    chk("ready_mid_reset", commit_ready, 0);
    step();
    reset = 1'b0;
    step();
    read_fflags(2'd0, "w0_after_reset", 0);
    read_frm(2'd3, "w3_frm_after_reset", 0);
    chk("busy_after_reset", csr_read_busy, 0);

    // Interleaved commits: warp 2 cycles distinct flags, warp 0 only NX
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive_commit(2'd2, 4'b0100, 1'b1, {5'h00, seq_flag[i/2], 10'h000});
      else            drive_commit(2'd0, 4'b0001, 1'b1, 20'h00001);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive_commit(2'd2, 4'b0001, 1'b1, {15'h0000, seq_flag[i]});
      step();
    end
    idle_commit();
    step();
    step();
    read_fflags(2'd2, "w2_all_flags", 5'h1F);
    read_fflags(2'd0, "w0_own_flags", 5'h01);
    read_fflags(2'd1, "w1_untouched", 0);
    chk("busy_idle_end", csr_read_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_fflags_csr.md
# fpu_fflags_csr

Consumer end of the FPU exception-flag path: collects per-lane `fflags_t` results committed by the FPU cores, reduces them under the thread mask, and accumulates them sticky into per-warp `fflags` state. Also holds per-warp `frm` and serves the CSR unit's reads and writes of `fflags`, `frm` and `fcsr`. Sits between the FPU commit/writeback port and the CSR unit.

## Interface
- `NUM_WARPS`, 4, number of warps with independent FP CSR state (≥1)
- `NUM_LANES`, 4, lanes per commit
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `commit_valid` in 1: FPU commit carries a result
- `commit_ready` out 1: block accepts the commit
- `commit_wid` in `$clog2(NUM_WARPS)`: warp id
- `commit_tmask` in `NUM_LANES`: active lanes
- `commit_has_fflags` in 1: the op can raise exceptions
- `commit_fflags` in `NUM_LANES`×`FFLAGS_BITS`: per-lane `fflags_t`
- `csr_read_wid` in `$clog2(NUM_WARPS)`: warp being read
- `csr_read_fflags` out 5: `fflags` of that warp
- `csr_read_frm` out 3: `frm` of that warp
- `csr_read_busy` out 1: read value not yet final; CSR unit must stall
- `csr_write_valid` in 1: write strobe
- `csr_write_wid` in `$clog2(NUM_WARPS)`: warp
- `csr_write_sel` in 2: 1 = fflags, 2 = frm, 3 = fcsr, 0 = no-op
- `csr_write_data` in 8: `fcsr` layout, `{frm[2:0], fflags[4:0]}`

## Operation
- Stage 0 (commit): on `commit_valid && commit_ready && commit_has_fflags`, OR-reduce `commit_fflags` over lanes where `commit_tmask` = 1. The result (5 bits) and `commit_wid` are captured into the stage-1 register `s1_valid/s1_wid/s1_flags`.
- Stage 1 (merge): when `s1_valid`, `fflags[s1_wid] <= fflags[s1_wid] | s1_flags`. Flags are sticky and are cleared only by a CSR write or reset.
- Commits with `commit_has_fflags` = 0, or with an all-zero tmask, do not set `s1_valid`.
- `commit_ready` = 1 whenever `reset` is low. The block never back-pressures the FPU.
- CSR write, applied at the clock edge:
  - sel 1: `fflags[wid] <= data[4:0]`
  - sel 2: `frm[wid] <= data[7:5]`
  - sel 3: both fields are written
- Simultaneous stage-1 merge and CSR write to the same warp: the merged op precedes the CSR instruction in program order, so the write wins on the fields it writes. If the write is frm-only, the fflags merge still applies.
- Reads are combinational from the state registers, with `csr_read_frm = frm[csr_read_wid]`.
- `frm` values 5 and 6 are reserved. They are stored as written, and the decode side raises an illegal instruction on them.

## Timing
- Commit-to-visible latency: flags from a commit in cycle N are in `fflags` after the edge ending cycle N+1 (two edges).
- `csr_read_busy` = `s1_valid && s1_wid == csr_read_wid` (without bypass), or a same-cycle qualifying commit to that warp. The CSR unit holds its read until busy drops, which takes at most 2 cycles.
- Reset values:
  - every `fflags[w]` = 0 and `frm[w]` = 0 (RNE)
  - `s1_valid` = 0, `commit_ready` = 0 during reset
  - outputs reflect the zeroed state
- Reset mid-operation discards a pending stage-1 merge.
- Back-to-back commits to one warp each merge. No flags are lost.

## Configuration
- `FPU_FFLAGS_BYPASS_EN` defined:
  - `csr_read_fflags` = `fflags[rid]`, ORed with `s1_flags` when `s1_valid && s1_wid == rid`
  - busy covers only a same-cycle stage-0 commit to `rid`
- Undefined: no forwarding, and busy covers stage 1 as described above. This saves a 5-bit mux per read port.

## Structure
- Package `fpu_types` additions:
  - existing `fflags_t` and `FFLAGS_BITS`
  - `frm` encodings: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7
  - CSR selector constants `FCSR_SEL_FFLAGS/FRM/ALL`
- Sub-module `fpu_fflags_reduce`: combinational masked OR over `NUM_LANES` `fflags_t`, which is reusable by the FPU response arbiter.
- Per-warp state is a flop array of `NUM_WARPS`×8 bits, not RAM, because reads are same-cycle.

## Test plan
- After reset, read warp 0 → fflags=0x00 and frm=0. Commit wid 2, tmask 0b0101, lane0 NX, lane2 DZ → two edges later, warp 2 reads 0x09 and warps 0, 1, 3 read 0.
- Commit with tmask 0b0010, lane1 OF, lane0 NV (masked off) → only 0x04 accumulates. `has_fflags`=0 with NV on all lanes → no change.
- Warp 1 holds 0x04, then a commit adds UF → 0x06. Read of warp 1 in the cycle after the commit: without bypass, busy=1 for 1 cycle, then 0x06; with bypass, busy=0 and 0x06 immediately.
- Same-cycle stage-1 merge of NX into warp 3 and `fcsr` write 0xE0 to warp 3 → fflags=0x00, frm=7. Repeat with a sel=2 write of 0x20 → frm=1 and NX is retained.
- Commit to warp 0 followed by `reset` asserted before the merge edge → warp 0 fflags=0 after reset, and `commit_ready`=0 during reset.
- Eight back-to-back commits to warp 2, each setting one distinct flag, interleaved with warp-0 commits → warp 2 reads 0x1F and warp 0 reads only its own flags.
